// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV64M multiply/divide sequencer: op encodings,
// FSM state type and op classification helper.
package muldiv_pkg;

  localparam logic [3:0] OP_MUL    = 4'b0000;
  localparam logic [3:0] OP_MULH   = 4'b0001;
  localparam logic [3:0] OP_MULHSU = 4'b0010;
  localparam logic [3:0] OP_MULHU  = 4'b0011;
  localparam logic [3:0] OP_DIV    = 4'b0100;
  localparam logic [3:0] OP_DIVU   = 4'b0101;
  localparam logic [3:0] OP_REM    = 4'b0110;
  localparam logic [3:0] OP_REMU   = 4'b0111;
  localparam logic [3:0] OP_MULW   = 4'b1000;
  localparam logic [3:0] OP_DIVW   = 4'b1100;
  localparam logic [3:0] OP_DIVUW  = 4'b1101;
  localparam logic [3:0] OP_REMW   = 4'b1110;
  localparam logic [3:0] OP_REMUW  = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_t;

  function automatic logic is_div(input logic [3:0] op);
    case (op)
      OP_DIV, OP_DIVU, OP_REM, OP_REMU,
      OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW: return 1'b1;
      default:                              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_iter_unit.sv
// One-bit-per-cycle datapath: right-shifting shift-add multiplier and
// left-shifting restoring divider sharing one 2*XLEN accumulator.
module muldiv_iter_unit #(
  parameter int XLEN = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic              div_mode,
  input  logic              word,
  input  logic [XLEN-1:0]   mag_a,
  input  logic [XLEN-1:0]   mag_b,
  output logic [2*XLEN-1:0] acc_next_o
);

  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic              div_q, div_d;
  logic [XLEN:0]     add_sum;
  logic [XLEN:0]     top;
  logic [XLEN:0]     diff;
  logic [2*XLEN-1:0] step_val;

  // Divider partial remainder is one bit wider than XLEN after the shift.
  always_comb begin
    add_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    top     = acc_q[2*XLEN-1:XLEN-1];
    diff    = top - {1'b0, opnd_q};
    if (div_q) begin
      if (top >= {1'b0, opnd_q}) step_val = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      else                       step_val = {top[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end else begin
      step_val = {add_sum, acc_q[XLEN-1:1]};
    end
  end

  // W divides park the 32-bit dividend in the top half of the low word so
  // that 32 steps leave the quotient in the low bits.
  always_comb begin
    acc_d  = acc_q;
    opnd_d = opnd_q;
    div_d  = div_q;
    if (load) begin
      div_d = div_mode;
      if (div_mode) begin
        acc_d  = {{XLEN{1'b0}}, (word ? (mag_a << (XLEN/2)) : mag_a)};
        opnd_d = mag_b;
      end else begin
        acc_d  = {{XLEN{1'b0}}, mag_b};
        opnd_d = mag_a;
      end
    end else if (step) begin
      acc_d = step_val;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q  <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      div_q  <= div_d;
    end
  end

  assign acc_next_o = step_val;

endmodule

// File: rtl/muldiv_seq_ctrl.sv
// EXC-stage sequencer for RV64M ops: decode, special-case fast path,
// iteration control, sign fix-up and the registered result.
module muldiv_seq_ctrl
  import muldiv_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int ITER_BITS = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_i,
  input  logic [3:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            ext_stall_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic [XLEN-1:0] result_o,
  output logic            result_valid_o,
  output logic            busy_o
);

  muldiv_state_t        state_q, state_d;
  logic [ITER_BITS-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]      result_q, result_d;
  logic                 rv_q, rv_d;
  logic                 busy_q, busy_d;
  logic [3:0]           op_q, op_d;
  logic                 neg_a_q, neg_a_d;
  logic                 sign_diff_q, sign_diff_d;

  logic                 word_in;
  logic [2:0]           f3_in;
  logic                 a_signed, b_signed;
  logic [XLEN-1:0]      a_ext, b_ext, mag_a, mag_b, min_val, fast_res;
  logic                 neg_a, neg_b, undef_w, div_zero, ovf, fast_hit;
  logic                 load, step;
  logic [2*XLEN-1:0]    acc_next, prod, prod_s;
  logic [XLEN-1:0]      quo, rem, res_iter;

  function automatic logic [XLEN-1:0] w_fix(input logic w, input logic [XLEN-1:0] x);
    return w ? {{(XLEN-32){x[31]}}, x[31:0]} : x;
  endfunction

  assign {word_in, f3_in} = op_i;

  // MULHSU is the only op whose operands differ in signedness.
  always_comb begin
    a_signed = !(f3_in == 3'b011 || f3_in == 3'b101 || f3_in == 3'b111);
    b_signed = (f3_in == 3'b000 || f3_in == 3'b001 || f3_in == 3'b100 || f3_in == 3'b110);
    a_ext    = word_in ? {{(XLEN-32){a_signed & a_i[31]}}, a_i[31:0]} : a_i;
    b_ext    = word_in ? {{(XLEN-32){b_signed & b_i[31]}}, b_i[31:0]} : b_i;
    neg_a    = a_signed & a_ext[XLEN-1];
    neg_b    = b_signed & b_ext[XLEN-1];
    mag_a    = neg_a ? -a_ext : a_ext;
    mag_b    = neg_b ? -b_ext : b_ext;
    min_val  = word_in ? {{(XLEN-31){1'b1}}, {31{1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    undef_w  = word_in & !f3_in[2] & (f3_in[1:0] != 2'b00);
    div_zero = is_div(op_i) & (b_ext == '0);
    ovf      = is_div(op_i) & !f3_in[0] & (a_ext == min_val) & (&b_ext);
    fast_hit = undef_w | div_zero | ovf;
    if (undef_w)       fast_res = '0;
    else if (div_zero) fast_res = f3_in[1] ? w_fix(word_in, a_ext) : '1;
    else               fast_res = f3_in[1] ? '0 : a_ext;
  end

  always_comb begin
    prod   = op_q[3] ? (acc_next >> (XLEN/2)) : acc_next;
    prod_s = sign_diff_q ? -prod : prod;
    quo    = acc_next[XLEN-1:0];
    rem    = acc_next[2*XLEN-1:XLEN];
    if (is_div(op_q))
      res_iter = op_q[1] ? (neg_a_q ? -rem : rem) : (sign_diff_q ? -quo : quo);
    else
      res_iter = (op_q[2:0] == 3'b000) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    rv_d        = 1'b0;
    busy_d      = 1'b0;
    op_d        = op_q;
    neg_a_d     = neg_a_q;
    sign_diff_d = sign_diff_q;
    load        = 1'b0;
    step        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (valid_i) begin
          op_d        = op_i;
          neg_a_d     = neg_a;
          sign_diff_d = neg_a ^ neg_b;
          if (fast_hit) begin
            result_d = fast_res;
            rv_d     = 1'b1;
            state_d  = ST_DONE;
          end else begin
            load    = 1'b1;
            busy_d  = 1'b1;
            cnt_d   = word_in ? ITER_BITS'(XLEN/2 - 1) : ITER_BITS'(XLEN - 1);
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        step = 1'b1;
        if (cnt_q == '0) begin
          result_d = w_fix(op_q[3], res_iter);
          rv_d     = 1'b1;
          state_d  = ST_DONE;
        end else begin
          busy_d = 1'b1;
          cnt_d  = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        if (ext_stall_i) rv_d = 1'b1;
        else             state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush_i) begin
      state_d = ST_IDLE;
      rv_d    = 1'b0;
      busy_d  = 1'b0;
      cnt_d   = '0;
      load    = 1'b0;
      step    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      result_q    <= '0;
      rv_q        <= 1'b0;
      busy_q      <= 1'b0;
      op_q        <= '0;
      neg_a_q     <= 1'b0;
      sign_diff_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      rv_q        <= rv_d;
      busy_q      <= busy_d;
      op_q        <= op_d;
      neg_a_q     <= neg_a_d;
      sign_diff_q <= sign_diff_d;
    end
  end

  muldiv_iter_unit #(.XLEN(XLEN)) u_iter (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .step       (step),
    .div_mode   (is_div(op_i)),
    .word       (word_in),
    .mag_a      (mag_a),
    .mag_b      (mag_b),
    .acc_next_o (acc_next)
  );

  // The IDLE term lets the pipeline hold in the very cycle the op arrives.
  assign stall_o        = reset & (busy_q | ((state_q == ST_IDLE) & valid_i & !flush_i));
  assign result_o       = result_q;
  assign result_valid_o = rv_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Self-checking bench for muldiv_seq_ctrl: vector table through a scoreboard
// plus hand-written hold, flush and reset sequences.
module tb_muldiv_seq_ctrl;

  logic        clk;
  logic        reset;
  logic        valid_i;
  logic [3:0]  op_i;
  logic [63:0] a_i;
  logic [63:0] b_i;
  logic        ext_stall_i;
  logic        flush_i;
  logic        stall_o;
  logic [63:0] result_o;
  logic        result_valid_o;
  logic        busy_o;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    int          stalls;
  } vec_t;

  typedef struct {
    logic [63:0] res;
    int          stalls;
  } exp_t;

  vec_t vecs [21];
  exp_t sb_q [$];

  muldiv_seq_ctrl #(.XLEN(64), .ITER_BITS(7)) dut (
    .clk            (clk),
    .reset          (reset),
    .valid_i        (valid_i),
    .op_i           (op_i),
    .a_i            (a_i),
    .b_i            (b_i),
    .ext_stall_i    (ext_stall_i),
    .flush_i        (flush_i),
    .stall_o        (stall_o),
    .result_o       (result_o),
    .result_valid_o (result_valid_o),
    .busy_o         (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one op, count stall cycles until result_valid_o, then compare
  // against the scoreboard. hold>0 keeps ext_stall_i high in DONE.
  task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] res, input int stalls, input int hold);
    exp_t e;
    int   seen_stalls;
    bit   seen;
    @(negedge clk);
    op_i    = op;
    a_i     = a;
    b_i     = b;
    valid_i = 1'b1;
    e.res    = res;
    e.stalls = stalls;
    sb_q.push_back(e);
    seen_stalls = 0;
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      #1;
      if (result_valid_o) seen = 1'b1;
      else begin
        if (stall_o) seen_stalls++;
        @(negedge clk);
      end
    end
    e = sb_q.pop_front();
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout op=%b: no result_valid_o within 200 cycles", op);
      valid_i = 1'b0;
      return;
    end
    $display("op=%b a=%h b=%h -> result=%h stalls=%0d", op, a, b, result_o, seen_stalls);
    chk("result", result_o, e.res);
    chk("stall_cycles", 64'(seen_stalls), 64'(e.stalls));
    chk("done_stall_low", {63'd0, stall_o}, 64'd0);
    if (hold > 0) begin
      ext_stall_i = 1'b1;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        #1;
        chk("hold_valid", {63'd0, result_valid_o}, 64'd1);
        chk("hold_result", result_o, e.res);
        chk("hold_stall", {63'd0, stall_o}, 64'd0);
        chk("hold_busy", {63'd0, busy_o}, 64'd0);
      end
      ext_stall_i = 1'b0;
    end
    valid_i = 1'b0;
    @(negedge clk);
    #1;
    chk("valid_pulse_end", {63'd0, result_valid_o}, 64'd0);
    chk("idle_stall", {63'd0, stall_o}, 64'd0);
  endtask

  initial begin
    int rv_seen;
    vecs[0]  = '{4'b0000, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 65};
    vecs[1]  = '{4'b0100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65};
    vecs[2]  = '{4'b0110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65};
    vecs[3]  = '{4'b0101, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    vecs[4]  = '{4'b0100, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1};
    vecs[5]  = '{4'b0110, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1};
    vecs[6]  = '{4'b1100, 64'h1_0000_0010, 64'd4, 64'd4, 33};
    vecs[7]  = '{4'b0001, 64'h8000_0000_0000_0000, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65};
    vecs[8]  = '{4'b0011, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 65};
    vecs[9]  = '{4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 65};
    vecs[10] = '{4'b1000, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33};
    vecs[11] = '{4'b1101, 64'hDEAD_0000_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 33};
    vecs[12] = '{4'b1111, 64'hFFFF_FFFF, 64'h10, 64'hF, 33};
    vecs[13] = '{4'b1110, 64'h1_8000_0005, 64'd0, 64'hFFFF_FFFF_8000_0005, 1};
    vecs[14] = '{4'b1100, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1};
    vecs[15] = '{4'b1001, 64'd5, 64'd7, 64'd0, 1};
    vecs[16] = '{4'b0101, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'h5555_5555_5555_5555, 65};
    vecs[17] = '{4'b0111, 64'd100, 64'd7, 64'd2, 65};
    vecs[18] = '{4'b0000, 64'h1234_5678, 64'h1_0000_0000, 64'h1234_5678_0000_0000, 65};
    vecs[19] = '{4'b1110, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33};
    vecs[20] = '{4'b1100, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33};

    reset       = 1'b0;
    valid_i     = 1'b0;
    op_i        = 4'd0;
    a_i         = '0;
    b_i         = '0;
    ext_stall_i = 1'b0;
    flush_i     = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_result", result_o, 64'd0);
    chk("reset_valid", {63'd0, result_valid_o}, 64'd0);
    chk("reset_busy", {63'd0, busy_o}, 64'd0);
    chk("reset_stall", {63'd0, stall_o}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 21; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].stalls, 0);

    // DONE held by an external stall with the EXA op still presented.
    run_op(4'b0000, 64'd6, 64'd7, 64'd42, 65, 5);

    // Flush in the tenth BUSY cycle.
    @(negedge clk);
    op_i    = 4'b0100;
    a_i     = 64'd100;
    b_i     = 64'd3;
    valid_i = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    chk("flush_busy_before", {63'd0, busy_o}, 64'd1);
    flush_i = 1'b1;
    valid_i = 1'b0;
    @(negedge clk);
    #1;
    flush_i = 1'b0;
    chk("flush_busy_after", {63'd0, busy_o}, 64'd0);
    chk("flush_stall_after", {63'd0, stall_o}, 64'd0);
    chk("flush_valid_after", {63'd0, result_valid_o}, 64'd0);
    rv_seen = 0;
    repeat (80) begin
      @(negedge clk);
      #1;
      if (result_valid_o) rv_seen++;
    end
    $display("flush sequence: result_valid_o cycles after flush=%0d", rv_seen);
    chk("flush_no_result", 64'(rv_seen), 64'd0);

    // Asynchronous reset mid-BUSY.
    @(negedge clk);
    op_i    = 4'b0000;
    a_i     = 64'd3;
    b_i     = 64'd5;
    valid_i = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    chk("pre_reset_busy", {63'd0, busy_o}, 64'd1);
    reset = 1'b0;
    #1;
    $display("reset sequence: result=%h valid=%b busy=%b stall=%b", result_o, result_valid_o, busy_o, stall_o);
    chk("midreset_result", result_o, 64'd0);
    chk("midreset_valid", {63'd0, result_valid_o}, 64'd0);
    chk("midreset_busy", {63'd0, busy_o}, 64'd0);
    chk("midreset_stall", {63'd0, stall_o}, 64'd0);
    @(negedge clk);
    valid_i = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    run_op(4'b0000, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 65, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/muldiv_seq_ctrl.md
Name: muldiv_seq_ctrl

Overview:
- Multi-cycle sequencer for the RV64M integer multiply/divide path in the EXC pipeline stage.
- Accepts an M-extension op from the EXA stage and runs an iterative shift-add multiplier or restoring divider.
- Holds the pipeline via stall_o until the result is ready, then presents it for one stage-advance.
- Resolves RISC-V divide special cases on a 1-cycle fast path.

Parameters:
- XLEN, 64, operand/result width; W ops use the low 32 bits.
- ITER_BITS, 7, width of the iteration counter; must hold XLEN.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low.
- valid_i  in  1  M-extension op present in EXA (m_sel_EXA).
- op_i  in  4  {is_word, funct3}: bit3 = W variant, bits[2:0] = RV funct3.
- a_i  in  XLEN  rs1 value.
- b_i  in  XLEN  rs2 value.
- ext_stall_i  in  1  pipeline stall from other sources.
- flush_i  in  1  kill the in-flight op (branch/trap).
- stall_o  out  1  hold request to the pipeline.
- result_o  out  XLEN  final result, registered.
- result_valid_o  out  1  result_o valid this cycle.
- busy_o  out  1  FSM in BUSY.

Behaviour:
- Reset (reset low, async): state = IDLE, counter = 0, result_o = 0, result_valid_o = 0, busy_o = 0, stall_o = 0. Reset mid-operation discards the op.
- FSM states: IDLE, BUSY, DONE.
- IDLE with valid_i:
  - Decode op, latch magnitudes and sign flags, assert stall_o combinationally.
  - Fast-path ops go to DONE next cycle with result registered.
  - All other ops load the iterator and go to BUSY with counter = N-1.
  - N = 64 for 64-bit ops, 32 for W ops.
- BUSY:
  - One bit per cycle.
  - stall_o = 1 and busy_o = 1.
  - Counter decrements. At counter = 0, apply sign fix-up, register result_o, go to DONE.
- DONE:
  - result_valid_o = 1, stall_o = 0.
  - ext_stall_i = 1: stay in DONE and hold result_o, so a stalled EXA op that is still present is not restarted.
  - ext_stall_i = 0: go to IDLE.
- Latency in stall cycles: N+1 iterative (65 for 64-bit ops, 33 for W ops), 1 on the fast path.
- flush_i in any state: go to IDLE next cycle, result_valid_o = 0. flush_i has priority over every other transition and over valid_i in IDLE.
- Multiply:
  - Operands are unsigned magnitudes, forming a 2*XLEN unsigned product; negate if the operand signs differ.
  - MUL returns low XLEN bits; MULH/MULHSU/MULHU return high XLEN bits.
  - MULHSU treats a as signed and b as unsigned.
- Divide:
  - Restoring divider on magnitudes.
  - Quotient is negated if the signs differ. Remainder takes the sign of the dividend.
- W ops:
  - Inputs are the low 32 bits, sign- or zero-extended per op.
  - Result is bit 31 sign-extended to XLEN; this includes DIVUW and REMUW.
- Fast path (registered, 1 stall cycle):
  - Divide by zero: quotient = all ones, remainder = dividend (sign-extended for W ops).
  - Signed overflow (MIN / -1): quotient = MIN, remainder = 0.
  - Undefined W encodings (funct3 001/010/011): result = 0.
- Simultaneous events:
  - valid_i deasserting in BUSY without flush_i is ignored; the op completes.
  - ext_stall_i does not pause BUSY.

Decomposition:
- muldiv_pkg holds:
  - Op localparams: MUL=0000, MULH=0001, MULHSU=0010, MULHU=0011, DIV=0100, DIVU=0101, REM=0110, REMU=0111, MULW=1000, DIVW=1100, DIVUW=1101, REMW=1110, REMUW=1111.
  - State enum muldiv_state_t.
  - Helper function is_div(op).
- One sub-module, muldiv_iter_unit:
  - Contains the shift-add/restoring datapath, 128-bit accumulator and one-bit-per-cycle step.
  - Controlled by load/step/mode inputs.
- muldiv_seq_ctrl owns the FSM, counter, fast path, sign fix-up and output register.

Test Plan:
- MUL a=3, b=-5 (0xFFFF_FFFF_FFFF_FFFB) -> stall_o high 65 cycles, then result_o = 0xFFFF_FFFF_FFFF_FFF1, result_valid_o for 1 cycle.
- DIV a=-7, b=2 -> 0xFFFF_FFFF_FFFF_FFFD. REM with the same operands -> 0xFFFF_FFFF_FFFF_FFFF.
- DIVU a=5, b=0 -> 1 stall cycle, result all ones. DIV a=0x8000_0000_0000_0000, b=-1 -> 0x8000_0000_0000_0000. REM with the same operands -> 0.
- DIVW a=0x1_0000_0010, b=4 -> 33 stall cycles, result 4. MULH a=0x8000_0000_0000_0000, b=2 -> 0xFFFF_FFFF_FFFF_FFFF.
- Hold in DONE with ext_stall_i=1 for 5 cycles, valid_i held -> result_o stable, no restart, stall_o low. Release ext_stall_i -> IDLE.
- Assert flush_i at BUSY cycle 10 -> IDLE next cycle, no result_valid_o. Pull reset low mid-BUSY -> all outputs 0 immediately.
